bcd_display_driver: RTL and testbench



---
 rtl/bcd_display_driver.sv | 125 ++++++++++++
 tb/tb_bcd_display_driver.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/bcd_display_driver.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_display_driver: sequential double-dabble binary-to-BCD converter     |
// | driving DIGITS seven-segment outputs. Option: BCD_LEADING_ZERO_BLANK_EN  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bcd_display_driver #(
  parameter int DATA_W         = 14,
  parameter int DIGITS         = 5,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     bin_i,
  input  logic                  start_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [7*DIGITS-1:0]   seg_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state;
  logic [DATA_W-1:0]    shift_reg;
  logic [4*DIGITS-1:0]  acc;
  logic [CNT_W-1:0]     count;
  logic [4*DIGITS-1:0]  acc_adj;
  logic [4*DIGITS-1:0]  acc_next;

  // Active-high pattern {g,f,e,d,c,b,a}; unreachable codes 10-15 blank.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  function automatic logic [7*DIGITS-1:0] encode(input logic [4*DIGITS-1:0] b);
    logic [7*DIGITS-1:0] s;
    logic [6:0]          p;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic                lead;
    lead = 1'b1;
`endif
    s = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      p = seg_digit(b[4*i +: 4]);
`ifdef BCD_LEADING_ZERO_BLANK_EN
      // Scanning from the top, digits stay blank until the first nonzero one.
      if (b[4*i +: 4] != 4'd0) lead = 1'b0;
      if (lead && (i != 0)) p = 7'b0000000;
`endif
      s[7*i +: 7] = (SEG_ACTIVE_LOW != 0) ? ~p : p;
    end
    return s;
  endfunction

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_next = {acc_adj[4*DIGITS-2:0], shift_reg[DATA_W-1]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ready_o   <= 1'b1;
      valid_o   <= 1'b0;
      bcd_o     <= '0;
      seg_o     <= encode('0);
      shift_reg <= '0;
      acc       <= '0;
      count     <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            shift_reg <= bin_i;
            acc       <= '0;
            count     <= '0;
            ready_o   <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= shift_reg << 1;
          acc       <= acc_next;
          count     <= count + 1'b1;
          if (count == LAST_ITER) begin
            bcd_o   <= acc_next;
            seg_o   <= encode(acc_next);
            valid_o <= 1'b1;
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_driver.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for bcd_display_driver: directed and random conversions checked
// against a decimal-arithmetic reference model.
module tb_bcd_display_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] bin_i;
  logic        start_i;
  logic        ready_o;
  logic        valid_o;
  logic [19:0] bcd_o;
  logic [34:0] seg_o;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  bcd_display_driver dut (
    .clk     (clk),
    .rst     (rst),
    .bin_i   (bin_i),
    .start_i (start_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .bcd_o   (bcd_o),
    .seg_o   (seg_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int p;
    r = '0;
    p = 1;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [34:0] ref_seg(input int v);
    logic [34:0] r;
    logic [6:0]  pat;
    int p;
    r = '0;
    p = 1;
    for (int d = 0; d < 5; d++) begin
      pat = seg_tbl[(v / p) % 10];
`ifdef BCD_LEADING_ZERO_BLANK_EN
      if (d > 0 && v < p) pat = 7'h00;
`endif
      r[7*d +: 7] = ~pat;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered one cycle before the intended accept edge with the DUT ready.
  task automatic run_conv(input int v, input bit hold, input int v5);
    bin_i   = 14'(v);
    start_i = 1'b1;
    step();
    if (!hold) begin
      start_i = 1'b0;
      bin_i   = 14'($urandom);
    end
    check("accepted", {ready_o, valid_o}, 2'b00);
    for (int k = 1; k <= 14; k++) begin
      if (hold && k == 5) bin_i = 14'(v5);
      step();
      if (k < 14) begin
        check("busy", {ready_o, valid_o}, 2'b00);
      end else begin
        check("done_flags", {ready_o, valid_o}, 2'b11);
        check("bcd", bcd_o, ref_bcd(v));
        check("seg", seg_o, ref_seg(v));
      end
    end
  endtask

  initial begin
    rst     = 1'b0;
    start_i = 1'b0;
    bin_i   = '0;
    step();
    step();
    check("rst_flags", {ready_o, valid_o}, 2'b10);
    check("rst_bcd", bcd_o, 20'h00000);
    check("rst_seg", seg_o, ref_seg(0));
    rst = 1'b1;
    step();
    check("idle_flags", {ready_o, valid_o}, 2'b10);

    run_conv(16383, 1'b0, 0);
    check("max_bcd_const", bcd_o, 20'h16383);
    step();
    check("pulse_end", {ready_o, valid_o}, 2'b10);
    step();
    check("hold_bcd", bcd_o, 20'h16383);

    run_conv(0, 1'b0, 0);
    run_conv(9999, 1'b0, 0);
    run_conv(10, 1'b0, 0);

    run_conv(123, 1'b1, 456);
    run_conv(456, 1'b0, 0);

    for (int n = 0; n < 8; n++) begin
      run_conv(int'($urandom_range(0, 16383)), 1'b0, 0);
    end
    run_conv(305, 1'b0, 0);
    start_i = 1'b0;
    step();
    check("rand_pulse_end", valid_o, 1'b0);

    bin_i   = 14'd777;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 1; k <= 6; k++) step();
    rst = 1'b0;
    step();
    check("mid_rst_flags", {ready_o, valid_o}, 2'b10);
    check("mid_rst_bcd", bcd_o, 20'h00000);
    check("mid_rst_seg", seg_o, ref_seg(0));
    rst = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      check("no_stale_valid", {ready_o, valid_o}, 2'b10);
    end
    run_conv(42, 1'b0, 0);
    check("fresh_bcd_const", bcd_o, 20'h00042);
    step();
    check("final_pulse_end", valid_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
